// File: rtl/gray_seq_gen.sv
// Registered up/down Gray-code sequence generator with parallel load and rdy backpressure.
// Defining GRAY_SEQ_CHECK_EN adds a sticky err output that flags non-single-bit Gray steps.
module gray_seq_gen #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dn,
  input  logic         ld,
  input  logic [W-1:0] ld_bin,
  input  logic         rdy,
  output logic [W-1:0] g,
  output logic [W-1:0] b,
  output logic         g_vld,
  output logic         tc,
  output logic         wrp
`ifdef GRAY_SEQ_CHECK_EN
  ,
  output logic         err
`endif
);

  localparam logic [W-1:0] ZERO     = {W{1'b0}};
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  function automatic logic [W-1:0] gray_of(input logic [W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic is_one_hot(input logic [W-1:0] x);
    return (x != ZERO) && ((x & (x - ONE)) == ZERO);
  endfunction

  logic [W-1:0] b_q, b_d;
  logic [W-1:0] g_q, g_d;
  logic         vld_q, vld_d;
  logic         wrp_q, wrp_d;
  logic         step_s;

  // next-state: load beats step, step beats hold
  always_comb begin
    step_s = en & rdy & ~ld;
    b_d    = b_q;
    vld_d  = 1'b0;
    wrp_d  = 1'b0;
    if (ld) begin
      b_d   = ld_bin;
      vld_d = 1'b1;
    end else if (step_s) begin
      vld_d = 1'b1;
      if (dn) begin
        b_d   = b_q - ONE;
        wrp_d = (b_q == ZERO);
      end else begin
        b_d   = b_q + ONE;
        wrp_d = (b_q == ALL_ONES);
      end
    end else begin
      b_d = b_q;
    end
    g_d = gray_of(b_d);
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q   <= RST_VAL;
      g_q   <= gray_of(RST_VAL);
      vld_q <= 1'b0;
      wrp_q <= 1'b0;
    end else begin
      b_q   <= b_d;
      g_q   <= g_d;
      vld_q <= vld_d;
      wrp_q <= wrp_d;
    end
  end

  // terminal count follows dn without a register stage
  always_comb begin
    if (dn) begin
      tc = (b_q == ZERO);
    end else begin
      tc = (b_q == ALL_ONES);
    end
  end

  assign g     = g_q;
  assign b     = b_q;
  assign g_vld = vld_q;
  assign wrp   = wrp_q;

`ifdef GRAY_SEQ_CHECK_EN
  logic err_q, err_d;

  // compares against the driven g so a corrupted output word is caught
  always_comb begin
    err_d = err_q;
    if (step_s && !is_one_hot(g_d ^ g)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_gray_seq_gen.sv
// Scoreboard bench for gray_seq_gen: a reference model pushes expected outputs per driven
// cycle and a monitor pops them after each rising edge. Exercises err when GRAY_SEQ_CHECK_EN is set.
module tb_gray_seq_gen;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
    logic       vld;
    logic       wrp;
  } exp_t;

  logic       clk;
  logic       rst, en, dn, ld, rdy;
  logic [3:0] ld_bin;
  logic [3:0] g, b;
  logic       g_vld, tc, wrp;
  logic       rst5, en5, dn5, ld5, rdy5;
  logic [3:0] ld_bin5;
  logic [3:0] g5, b5;
  logic       g_vld5, tc5, wrp5;
`ifdef GRAY_SEQ_CHECK_EN
  logic       err, err5;
`endif

  int         n_chk = 0;
  int         n_err = 0;
  exp_t       sb[$];
  logic [3:0] b_m;
  logic       vld_m, wrp_m, mdl_ok;
  int         wrp_cnt;
  logic [3:0] gtab [16];

  gray_seq_gen #(.W(4), .RST_VAL(4'd0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .dn(dn), .ld(ld), .ld_bin(ld_bin), .rdy(rdy),
    .g(g), .b(b), .g_vld(g_vld), .tc(tc), .wrp(wrp)
`ifdef GRAY_SEQ_CHECK_EN
    , .err(err)
`endif
  );

  gray_seq_gen #(.W(4), .RST_VAL(4'd5)) u_dut5 (
    .clk(clk), .rst(rst5), .en(en5), .dn(dn5), .ld(ld5), .ld_bin(ld_bin5), .rdy(rdy5),
    .g(g5), .b(b5), .g_vld(g_vld5), .tc(tc5), .wrp(wrp5)
`ifdef GRAY_SEQ_CHECK_EN
    , .err(err5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor: pop one expectation per edge once outputs have settled
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check_val("b", {28'd0, b}, {28'd0, x.b});
      check_val("g", {28'd0, g}, {28'd0, x.g});
      check_val("g_vld", {31'd0, g_vld}, {31'd0, x.vld});
      check_val("wrp", {31'd0, wrp}, {31'd0, x.wrp});
      if (wrp === 1'b1) wrp_cnt++;
    end
  end

  // drive one cycle, check tc against the model, push the expected post-edge state
  task automatic cyc(input logic r, input logic e, input logic d, input logic l,
                     input logic [3:0] lb, input logic rd);
    exp_t x;
    rst = r; en = e; dn = d; ld = l; ld_bin = lb; rdy = rd;
    #1;
    if (mdl_ok) check_val("tc", {31'd0, tc}, {31'd0, (d ? (b_m == 4'd0) : (b_m == 4'd15))});
    if (r) begin
      b_m = 4'd0; vld_m = 1'b0; wrp_m = 1'b0; mdl_ok = 1'b1;
    end else if (l) begin
      b_m = lb; vld_m = 1'b1; wrp_m = 1'b0;
    end else if (e && rd) begin
      vld_m = 1'b1;
      if (d) begin
        wrp_m = (b_m == 4'd0); b_m = b_m - 4'd1;
      end else begin
        wrp_m = (b_m == 4'd15); b_m = b_m + 4'd1;
      end
    end else begin
      vld_m = 1'b0; wrp_m = 1'b0;
    end
    x.b = b_m; x.g = gtab[b_m]; x.vld = vld_m; x.wrp = wrp_m;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  initial begin
    gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    mdl_ok = 1'b0; b_m = 4'd0; vld_m = 1'b0; wrp_m = 1'b0; wrp_cnt = 0;
    rst5 = 1'b1; en5 = 1'b0; dn5 = 1'b0; ld5 = 1'b0; ld_bin5 = 4'd0; rdy5 = 1'b1;
    rst = 1'b1; en = 1'b0; dn = 1'b0; ld = 1'b0; ld_bin = 4'd0; rdy = 1'b0;
    @(negedge clk);

    // reset then a full up sweep with wrap back to 0
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    check_val("rst_vld", {31'd0, g_vld}, 32'd0);
    wrp_cnt = 0;
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    check_val("sweep_end_g", {28'd0, g}, 32'd0);
    check_val("sweep_wrp_cnt", wrp_cnt, 32'd1);

    // down step from 0 wraps to F
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    check_val("dn_wrap_g", {28'd0, g}, 32'h8);
    check_val("dn_wrap_wrp", {31'd0, wrp}, 32'd1);
    dn = 1'b1; en = 1'b0; #1;
    check_val("tc_dn1", {31'd0, tc}, 32'd0);
    dn = 1'b0; #1;
    check_val("tc_dn0", {31'd0, tc}, 32'd1);

    // load wins over en; rdy low holds
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0);
    check_val("ld_g", {28'd0, g}, 32'hF);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check_val("hold_b", {28'd0, b}, 32'hA);
    check_val("hold_vld", {31'd0, g_vld}, 32'd0);

    // reset mid-sequence at b=6 with en, ld, rdy pending
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    check_val("mid_g", {28'd0, g}, 32'h5);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 1'b1);
    check_val("mid_rst_b", {28'd0, b}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);

    // randomised traffic, including occasional resets and loads
    for (int i = 0; i < 60; i++) begin
      cyc(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

`ifdef GRAY_SEQ_CHECK_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1);
    check_val("err_clean", {31'd0, err}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
    // corrupt g across one step edge: 6 -> gray(1)=1 differs in three bits
    @(negedge clk);
    force u_dut.g = 4'h6;
    rst = 1'b0; en = 1'b1; dn = 1'b0; ld = 1'b0; rdy = 1'b1;
    @(posedge clk);
    #1;
    release u_dut.g;
    b_m = 4'd1;
    #1;
    check_val("err_set", {31'd0, err}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1);
    check_val("err_sticky", {31'd0, err}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    check_val("err_rst", {31'd0, err}, 32'd0);
`endif

    // RST_VAL=5 instance
    @(negedge clk);
    rst5 = 1'b0; en5 = 1'b0;
    #1;
    check_val("r5_b", {28'd0, b5}, 32'd5);
    check_val("r5_g", {28'd0, g5}, 32'd7);
    check_val("r5_tc", {31'd0, tc5}, 32'd0);
    check_val("r5_vld", {31'd0, g_vld5}, 32'd0);
    en5 = 1'b1;
    @(posedge clk);
    #1;
    en5 = 1'b0;
    check_val("r5_step_b", {28'd0, b5}, 32'd6);
    check_val("r5_step_g", {28'd0, g5}, 32'd5);
    check_val("r5_step_vld", {31'd0, g_vld5}, 32'd1);

    #20;
    check_val("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
